// File: rtl/spi_flash_resp.sv
// SPI mode-0 responder emulating the status-register subset of a serial NOR flash.
// Define SPI_RESP_SR2_EN to add RDSR2 (0x35), WRSR2 (0x31) and 16-bit WRSR.
module spi_flash_resp #(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter logic [7:0]  SR1_INIT    = 8'h00,
    parameter logic [7:0]  SR2_INIT    = 8'h02,
    parameter int unsigned BUSY_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] sr1,
    output logic [7:0] sr2,
    output logic       wr_stb,
    output logic       busy
);

`ifdef SPI_RESP_SR2_EN
    localparam bit SR2_EN = 1'b1;
`else
    localparam bit SR2_EN = 1'b0;
`endif

    localparam int            CW        = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_IGNORE, S_DOUT, S_DIN} state_t;
    typedef enum logic [2:0] {A_NONE, A_WREN, A_WRDI, A_WRSR, A_WRSR2} action_t;
    typedef enum logic [1:0] {SRC_SR1, SRC_SR2, SRC_ID} src_t;

    logic [1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_d, cs_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall, mosi_bit;

    // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_d     <= sck_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;
    assign cs_fall  = ~cs_sync[1] & cs_d;
    assign cs_rise  = cs_sync[1] & ~cs_d;
    assign mosi_bit = mosi_sync[1];

    state_t        state;
    action_t       action;
    src_t          src;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [1:0]    id_idx;
    logic [7:0]    shift_reg, out_shift, data0, data1, rx_byte, dout_byte;
    logic [5:0]    sr1_bits;
    logic          wel;
    logic [7:0]    sr2_reg;
    logic [CW-1:0] busy_cnt;
    logic          wrsr_ok, wrsr2_ok, bare_cmd;

    assign sr1     = {sr1_bits, wel, busy};
    assign sr2     = sr2_reg;
    assign rx_byte = {shift_reg[6:0], mosi_bit};

    // Whole bytes only: a trailing partial byte or extra bits cancel the commit.
    assign bare_cmd = (bit_cnt == 3'd0) && (byte_cnt == 2'd0);
    assign wrsr_ok  = wel && !busy && (bit_cnt == 3'd0) &&
                      ((byte_cnt == 2'd1) || (SR2_EN && byte_cnt == 2'd2));
    assign wrsr2_ok = SR2_EN && wel && !busy && (bit_cnt == 3'd0) && (byte_cnt == 2'd1);

    // NOTE: default assignment first so no path leaves dout_byte unassigned (no latch).
    always_comb begin
        dout_byte = 8'hFF;
        case (src)
            SRC_SR1: dout_byte = sr1;
            SRC_SR2: dout_byte = sr2_reg;
            default: begin
                case (id_idx)
                    2'd0:    dout_byte = JEDEC_ID[23:16];
                    2'd1:    dout_byte = JEDEC_ID[15:8];
                    2'd2:    dout_byte = JEDEC_ID[7:0];
                    default: dout_byte = 8'hFF;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            action    <= A_NONE;
            src       <= SRC_SR1;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            id_idx    <= 2'd0;
            shift_reg <= 8'h00;
            out_shift <= 8'h00;
            data0     <= 8'h00;
            data1     <= 8'h00;
            sr1_bits  <= SR1_INIT[7:2];
            wel       <= 1'b0;
            sr2_reg   <= SR2_INIT & 8'h7F;
            busy      <= 1'b0;
            busy_cnt  <= '0;
            wr_stb    <= 1'b0;
            spi_miso  <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (busy) begin
                if (busy_cnt == '0) busy     <= 1'b0;
                else                busy_cnt <= busy_cnt - CW'(1);
            end

            if (cs_rise) begin
                state    <= S_IDLE;
                spi_miso <= 1'b0;
                bit_cnt  <= 3'd0;
                action   <= A_NONE;
                case (action)
                    A_WREN: if (bare_cmd && !busy) wel <= 1'b1;
                    A_WRDI: if (bare_cmd && !busy) wel <= 1'b0;
                    A_WRSR: if (wrsr_ok) begin
                        sr1_bits <= data0[7:2];
                        if (byte_cnt == 2'd2) sr2_reg <= data1 & 8'h7F;
                        wel      <= 1'b0;
                        busy     <= 1'b1;
                        busy_cnt <= BUSY_LOAD;
                        wr_stb   <= 1'b1;
                    end
                    A_WRSR2: if (wrsr2_ok) begin
                        sr2_reg  <= data0 & 8'h7F;
                        wel      <= 1'b0;
                        busy     <= 1'b1;
                        busy_cnt <= BUSY_LOAD;
                        wr_stb   <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (cs_fall) begin
                state    <= S_CMD;
                action   <= A_NONE;
                bit_cnt  <= 3'd0;
                byte_cnt <= 2'd0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    S_CMD: if (sck_rise) begin
                        shift_reg <= rx_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_IGNORE;
                            case (rx_byte)
                                8'h06: action <= busy ? A_NONE : A_WREN;
                                8'h04: action <= busy ? A_NONE : A_WRDI;
                                8'h05: begin
                                    state     <= S_DOUT;
                                    src       <= SRC_SR1;
                                    out_shift <= sr1;
                                end
                                8'h35: if (SR2_EN) begin
                                    state     <= S_DOUT;
                                    src       <= SRC_SR2;
                                    out_shift <= sr2_reg;
                                end
                                8'h9F: if (!busy) begin
                                    state     <= S_DOUT;
                                    src       <= SRC_ID;
                                    id_idx    <= 2'd1;
                                    out_shift <= JEDEC_ID[23:16];
                                end
                                8'h01: if (!busy) begin
                                    state  <= S_DIN;
                                    action <= A_WRSR;
                                end
                                8'h31: if (SR2_EN && !busy) begin
                                    state  <= S_DIN;
                                    action <= A_WRSR2;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_IGNORE: if (sck_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7 && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                    end
                    S_DIN: if (sck_rise) begin
                        shift_reg <= rx_byte;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == 2'd0) data0 <= rx_byte;
                            if (byte_cnt == 2'd1) data1 <= rx_byte;
                            if (byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                    S_DOUT: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            // Byte boundary: re-read the source so a clearing BUSY shows up.
                            if (bit_cnt == 3'd7) begin
                                out_shift <= dout_byte;
                                if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                            end
                        end else if (sck_fall) begin
                            spi_miso  <= out_shift[7];
                            out_shift <= {out_shift[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_resp.sv
// Self-checking bench for spi_flash_resp: directed scenarios plus randomized
// transactions compared against a transaction-level flash model.
module tb_spi_flash_resp;

    localparam int BUSY_CYCLES = 1000;
    localparam int HALF        = 60;

`ifdef SPI_RESP_SR2_EN
    localparam bit SR2 = 1'b1;
`else
    localparam bit SR2 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] sr1, sr2;
    logic       wr_stb, busy;

    spi_flash_resp #(.BUSY_CYCLES(BUSY_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .sr1(sr1), .sr2(sr2),
        .wr_stb(wr_stb), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Flash model: stored sr1 bits, WEL, BUSY, sr2, expected strobe count.
    logic [7:0] m_bits = 8'h00;
    logic       m_wel = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] m_sr2 = 8'h02;
    int         exp_stb = 0;

    int stb_cnt = 0;
    int busy_run = 0;
    int last_busy_len = 0;

    always @(negedge clk) begin
        if (wr_stb) stb_cnt++;
        if (busy) busy_run++;
        else begin
            if (busy_run != 0) last_busy_len = busy_run;
            busy_run = 0;
        end
    end

    function automatic logic [7:0] m_sr1();
        return {m_bits[7:2], m_wel, m_busy};
    endfunction

    // Byte k (k>=1) the flash should return after opcode op.
    function automatic logic [7:0] exp_read(input logic [7:0] op, input int k);
        logic [23:0] id;
        id = 24'hEF4016;
        if (op == 8'h05) return m_sr1();
        if (op == 8'h35) return SR2 ? m_sr2 : 8'h00;
        if (op == 8'h9F && !m_busy) begin
            if (k <= 3) return id[8*(3-k) +: 8];
            return 8'hFF;
        end
        return 8'h00;
    endfunction

    task automatic model_commit(input logic [7:0] tx[$], input int nbits);
        logic [7:0] op;
        op = tx[0];
        if (nbits < 8 || m_busy) return;
        if (op == 8'h06 && nbits == 8) m_wel = 1'b1;
        else if (op == 8'h04 && nbits == 8) m_wel = 1'b0;
        else if (op == 8'h01 && m_wel && (nbits == 16 || (SR2 && nbits == 24))) begin
            m_bits = tx[1] & 8'hFC;
            if (nbits == 24) m_sr2 = tx[2] & 8'h7F;
            m_wel = 1'b0; m_busy = 1'b1; exp_stb++;
        end else if (op == 8'h31 && SR2 && m_wel && nbits == 16) begin
            m_sr2 = tx[1] & 8'h7F;
            m_wel = 1'b0; m_busy = 1'b1; exp_stb++;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            #HALF;
            rx[7-i] = spi_miso;
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] tx[$], input int nbits, output logic [7:0] rx[$]);
        logic [7:0] b, r;
        int left;
        rx = {};
        spi_cs_n = 1'b0;
        #HALF;
        left = nbits;
        for (int k = 0; left > 0; k++) begin
            b = (k < tx.size()) ? tx[k] : 8'h00;
            spi_bits(b, (left > 8) ? 8 : left, r);
            rx.push_back(r);
            left -= 8;
        end
        #HALF;
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        model_commit(tx, nbits);
    endtask

    task automatic wait_busy_clear();
        repeat (BUSY_CYCLES + 10) @(posedge clk);
        m_busy = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] tx[$], rx[$];
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (sr1 !== 8'h00) begin failures++; $display("FAIL reset_sr1 got %h exp %h", sr1, 8'h00); end
        if (sr2 !== 8'h02) begin failures++; $display("FAIL reset_sr2 got %h exp %h", sr2, 8'h02); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (wr_stb !== 1'b0) begin failures++; $display("FAIL reset_wr_stb got %b exp 0", wr_stb); end
        if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        tx = {8'h05};
        txn(tx, 16, rx);
        checks++;
        if (rx[1] !== 8'h00) begin failures++; $display("FAIL reset_rdsr1 got %h exp %h", rx[1], 8'h00); end
    endtask

    task automatic test_wrsr();
        logic [7:0] tx[$], rx[$];
        int s0;
        s0 = stb_cnt;
        tx = {8'h06}; txn(tx, 8, rx);
        checks++;
        if (sr1 !== 8'h02) begin failures++; $display("FAIL wren_wel got %h exp %h", sr1, 8'h02); end
        tx = {8'h01, 8'h1C}; txn(tx, 16, rx);
        checks += 3;
        if (stb_cnt - s0 !== 1) begin failures++; $display("FAIL wrsr_stb got %0d exp 1", stb_cnt - s0); end
        if (sr1 !== 8'h1D) begin failures++; $display("FAIL wrsr_sr1_busy got %h exp %h", sr1, 8'h1D); end
        if (busy !== 1'b1) begin failures++; $display("FAIL wrsr_busy got %b exp 1", busy); end
        tx = {8'h05}; txn(tx, 16, rx);
        checks++;
        if (rx[1] !== 8'h1D) begin failures++; $display("FAIL rdsr1_busy got %h exp %h", rx[1], 8'h1D); end
        wait_busy_clear();
        checks++;
        if (last_busy_len !== BUSY_CYCLES) begin
            failures++; $display("FAIL busy_len got %0d exp %0d", last_busy_len, BUSY_CYCLES);
        end
        tx = {8'h05}; txn(tx, 24, rx);
        checks += 3;
        if (rx[1] !== 8'h1C) begin failures++; $display("FAIL rdsr1_after got %h exp %h", rx[1], 8'h1C); end
        if (rx[2] !== 8'h1C) begin failures++; $display("FAIL rdsr1_repeat got %h exp %h", rx[2], 8'h1C); end
        if (sr1 !== 8'h1C) begin failures++; $display("FAIL sr1_after got %h exp %h", sr1, 8'h1C); end
    endtask

    task automatic test_no_wren();
        logic [7:0] tx[$], rx[$];
        int s0;
        s0 = stb_cnt;
        tx = {8'h01, 8'h30}; txn(tx, 16, rx);
        checks += 2;
        if (stb_cnt !== s0) begin failures++; $display("FAIL nowel_stb got %0d exp %0d", stb_cnt, s0); end
        if (sr1 !== 8'h1C) begin failures++; $display("FAIL nowel_sr1 got %h exp %h", sr1, 8'h1C); end
        tx = {8'h06}; txn(tx, 5, rx);
        checks++;
        if (sr1[1] !== 1'b0) begin failures++; $display("FAIL wren_short got %b exp 0", sr1[1]); end
        tx = {8'h06}; txn(tx, 11, rx);
        checks++;
        if (sr1[1] !== 1'b0) begin failures++; $display("FAIL wren_long got %b exp 0", sr1[1]); end
        tx = {8'h06}; txn(tx, 8, rx);
        tx = {8'h01, 8'hF0}; txn(tx, 13, rx);
        checks += 2;
        if (stb_cnt !== s0) begin failures++; $display("FAIL partial_stb got %0d exp %0d", stb_cnt, s0); end
        if (sr1 !== 8'h1E) begin failures++; $display("FAIL partial_sr1 got %h exp %h", sr1, 8'h1E); end
        tx = {8'h04}; txn(tx, 8, rx);
        checks++;
        if (sr1 !== 8'h1C) begin failures++; $display("FAIL wrdi got %h exp %h", sr1, 8'h1C); end
    endtask

    task automatic test_rdid();
        logic [7:0] tx[$], rx[$];
        logic [7:0] exp_id [0:3];
        exp_id = '{8'hEF, 8'h40, 8'h16, 8'hFF};
        tx = {8'h9F}; txn(tx, 40, rx);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (rx[k] !== exp_id[k-1]) begin
                failures++; $display("FAIL rdid_byte%0d got %h exp %h", k, rx[k], exp_id[k-1]);
            end
        end
        tx = {8'hAB}; txn(tx, 24, rx);
        checks += 3;
        if (rx[1] !== 8'h00 || rx[2] !== 8'h00) begin
            failures++; $display("FAIL unknown_miso got %h%h exp 0000", rx[1], rx[2]);
        end
        if (sr1 !== 8'h1C) begin failures++; $display("FAIL unknown_sr1 got %h exp %h", sr1, 8'h1C); end
        if (sr2 !== 8'h02) begin failures++; $display("FAIL unknown_sr2 got %h exp %h", sr2, 8'h02); end
    endtask

    task automatic test_sr2();
        logic [7:0] tx[$], rx[$];
        int s0;
        s0 = stb_cnt;
        tx = {8'h06}; txn(tx, 8, rx);
        tx = {8'h01, 8'h00, 8'h82}; txn(tx, 24, rx);
        checks += 3;
        if (stb_cnt - s0 !== (SR2 ? 1 : 0)) begin
            failures++; $display("FAIL wrsr16_stb got %0d exp %0d", stb_cnt - s0, SR2 ? 1 : 0);
        end
        if (sr2 !== 8'h02) begin failures++; $display("FAIL wrsr16_sr2 got %h exp %h", sr2, 8'h02); end
        if (sr1 !== (SR2 ? 8'h01 : 8'h1E)) begin
            failures++; $display("FAIL wrsr16_sr1 got %h exp %h", sr1, SR2 ? 8'h01 : 8'h1E);
        end
        if (m_busy) wait_busy_clear();
        tx = {8'h06}; txn(tx, 8, rx);
        tx = {8'h31, 8'hFF}; txn(tx, 16, rx);
        checks += 2;
        if (sr2 !== (SR2 ? 8'h7F : 8'h02)) begin
            failures++; $display("FAIL wrsr2_sr2 got %h exp %h", sr2, SR2 ? 8'h7F : 8'h02);
        end
        if (stb_cnt - s0 !== (SR2 ? 2 : 0)) begin
            failures++; $display("FAIL wrsr2_stb got %0d exp %0d", stb_cnt - s0, SR2 ? 2 : 0);
        end
        if (m_busy) wait_busy_clear();
        tx = {8'h35}; txn(tx, 16, rx);
        checks++;
        if (rx[1] !== (SR2 ? 8'h7F : 8'h00)) begin
            failures++; $display("FAIL rdsr2 got %h exp %h", rx[1], SR2 ? 8'h7F : 8'h00);
        end
        tx = {8'h04}; txn(tx, 8, rx);
        checks++;
        if (sr1 !== m_sr1()) begin failures++; $display("FAIL sr2_end_sr1 got %h exp %h", sr1, m_sr1()); end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] tx[$], rx[$];
        tx = {8'h06}; txn(tx, 8, rx);
        tx = {8'h01, 8'h24}; txn(tx, 16, rx);
        tx = {8'h06}; txn(tx, 8, rx);
        checks++;
        if (sr1 !== 8'h25) begin failures++; $display("FAIL busy_wren got %h exp %h", sr1, 8'h25); end
        tx = {8'h9F}; txn(tx, 16, rx);
        checks++;
        if (rx[1] !== 8'h00) begin failures++; $display("FAIL busy_rdid got %h exp %h", rx[1], 8'h00); end
        wait_busy_clear();
        checks += 2;
        if (sr1 !== 8'h24) begin failures++; $display("FAIL busy_clear_sr1 got %h exp %h", sr1, 8'h24); end
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_clear got %b exp 0", busy); end
    endtask

    task automatic test_random();
        logic [7:0] tx[$], rx[$], ex[$];
        logic [7:0] ops [0:7];
        logic [7:0] op;
        int nbits;
        ops = '{8'h05, 8'h06, 8'h04, 8'h01, 8'h9F, 8'h35, 8'h31, 8'hC7};
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                tx = {8'h06}; txn(tx, 8, rx);
            end
            op = ops[$urandom_range(0, 7)];
            if (op == 8'hC7) op = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'hC7;
            tx = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
            case (op)
                8'h01: begin
                    case ($urandom_range(0, 2))
                        0:       nbits = 16;
                        1:       nbits = 24;
                        default: nbits = 8 + int'($urandom_range(1, 20));
                    endcase
                end
                8'h06, 8'h04: nbits = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(3, 17));
                8'h31:        nbits = ($urandom_range(0, 1) == 1) ? 16 : 12;
                default:      nbits = 8 + 8 * int'($urandom_range(0, 3));
            endcase
            ex = {};
            for (int k = 1; 8 * (k + 1) <= nbits; k++) ex.push_back(exp_read(op, k));
            txn(tx, nbits, rx);
            for (int k = 1; k <= ex.size(); k++) begin
                checks++;
                if (rx[k] !== ex[k-1]) begin
                    failures++;
                    $display("FAIL rand_read it=%0d op=%h byte%0d got %h exp %h", it, op, k, rx[k], ex[k-1]);
                end
            end
            checks += 3;
            if (sr1 !== m_sr1()) begin
                failures++; $display("FAIL rand_sr1 it=%0d op=%h bits=%0d got %h exp %h", it, op, nbits, sr1, m_sr1());
            end
            if (sr2 !== m_sr2) begin
                failures++; $display("FAIL rand_sr2 it=%0d got %h exp %h", it, sr2, m_sr2);
            end
            if (stb_cnt !== exp_stb) begin
                failures++; $display("FAIL rand_stb it=%0d got %0d exp %0d", it, stb_cnt, exp_stb);
            end
            if (m_busy) wait_busy_clear();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] tx[$], rx[$];
        logic [7:0] r;
        int s0;
        tx = {8'h06}; txn(tx, 8, rx);
        s0 = stb_cnt;
        spi_cs_n = 1'b0;
        #HALF;
        spi_bits(8'h01, 8, r);
        spi_bits(8'hA8, 4, r);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (sr1 !== 8'h00) begin failures++; $display("FAIL midrst_sr1 got %h exp %h", sr1, 8'h00); end
        if (sr2 !== 8'h02) begin failures++; $display("FAIL midrst_sr2 got %h exp %h", sr2, 8'h02); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", busy); end
        if (wr_stb !== 1'b0) begin failures++; $display("FAIL midrst_wr_stb got %b exp 0", wr_stb); end
        if (spi_miso !== 1'b0) begin failures++; $display("FAIL midrst_miso got %b exp 0", spi_miso); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        m_bits = 8'h00; m_wel = 1'b0; m_busy = 1'b0; m_sr2 = 8'h02;
        checks++;
        if (stb_cnt !== s0) begin failures++; $display("FAIL midrst_stb got %0d exp %0d", stb_cnt, s0); end
        tx = {8'h05}; txn(tx, 16, rx);
        checks += 2;
        if (rx[1] !== 8'h00) begin failures++; $display("FAIL midrst_rdsr1 got %h exp %h", rx[1], 8'h00); end
        if (sr1 !== 8'h00) begin failures++; $display("FAIL midrst_sr1_after got %h exp %h", sr1, 8'h00); end
    endtask

    initial begin
        test_reset();
        test_wrsr();
        test_no_wren();
        test_rdid();
        test_sr2();
        test_busy_ignore();
        exp_stb = stb_cnt - (stb_cnt - exp_stb);
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
